// File: rtl/fir91_pkg.sv
// Shared widths, types, saturation limits and default coefficient contents
// for the reloadable-coefficient FIR filter.
package fir91_pkg;

    localparam int DIN_WIDTH  = 16;
    localparam int COEF_WIDTH = 19;
    localparam int NUM_TAPS   = 80;
    localparam int DOUT_WIDTH = 38;

    // Full-precision accumulator: every product plus growth for NUM_TAPS terms.
    localparam int ACC_WIDTH  = DIN_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS);
    localparam int IDX_WIDTH  = $clog2(NUM_TAPS);

    typedef logic signed [DIN_WIDTH-1:0]  din_t;
    typedef logic signed [COEF_WIDTH-1:0] coef_t;
    typedef logic signed [DOUT_WIDTH-1:0] dout_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;
    typedef logic [IDX_WIDTH-1:0]         idx_t;
    typedef logic [1:0]                   err_t;

    // One bank is NUM_TAPS raw coefficient words; both banks side by side.
    typedef logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] bank_t;
    typedef bank_t [1:0]                         banks_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_TAPS - 1);

    // Signed DOUT_WIDTH range expressed in accumulator width.
    localparam acc_t SAT_MAX = acc_t'({{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}});
    localparam acc_t SAT_MIN = acc_t'({{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}});

    // Power-up bank contents: bank0 is a unit impulse, bank1 a gain-2 impulse.
    function automatic coef_t default_coef(logic set, idx_t tap);
        if (tap != '0) begin
            return '0;
        end
        return set ? coef_t'(2) : coef_t'(1);
    endfunction

    // One product term, sign-extended to accumulator width before multiplying.
    function automatic acc_t mac_term(din_t x, coef_t c);
        return acc_t'(x) * acc_t'(c);
    endfunction

    // Clamp the accumulator into the signed output range.
    function automatic dout_t saturate(acc_t a);
        if (a > SAT_MAX) begin
            return dout_t'(SAT_MAX);
        end
        if (a < SAT_MIN) begin
            return dout_t'(SAT_MIN);
        end
        return a[DOUT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/fir91_coef_reload_if.sv
// Bus bundle for one filter channel: Avalon-ST sink/source, per-sample bank
// select and the coefficient reload port.
//
// Handshake: a sample transfers on a rising edge where ast_sink_valid and
// ast_sink_ready are both 1; a result transfers on a rising edge where
// ast_source_valid and ast_source_ready are both 1. While a result is offered
// and not taken, ast_source_data/valid/error stay unchanged. ast_sink_ready may
// depend combinationally on ast_source_ready. The reload port has no ready:
// coef_we is a per-cycle strobe and coef_in follows it by exactly one cycle.
interface fir91_coef_reload_if;
    import fir91_pkg::*;

    din_t  ast_sink_data;
    logic  ast_sink_valid;
    err_t  ast_sink_error;
    logic  ast_sink_ready;
    logic  coef_set;
    logic  ast_source_ready;
    dout_t ast_source_data;
    logic  ast_source_valid;
    err_t  ast_source_error;
    logic  coef_we;
    logic  coef_set_in;
    coef_t coef_in;

    // Upstream/controller side
    modport master (
        output ast_sink_data, ast_sink_valid, ast_sink_error, coef_set,
        output ast_source_ready, coef_we, coef_set_in, coef_in,
        input  ast_sink_ready, ast_source_data, ast_source_valid, ast_source_error
    );

    // Filter side
    modport slave (
        input  ast_sink_data, ast_sink_valid, ast_sink_error, coef_set,
        input  ast_source_ready, coef_we, coef_set_in, coef_in,
        output ast_sink_ready, ast_source_data, ast_source_valid, ast_source_error
    );

endinterface

// File: rtl/fir91_coef_bank.sv
// Two-bank coefficient register file with a streaming reload port. The
// coefficient word arrives one cycle after its strobe, so strobe and target
// bank are delayed by one cycle and the write happens when the data is present.
module fir91_coef_bank
    import fir91_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_coef_we,
    input  logic   i_coef_set_in,
    input  coef_t  i_coef_in,
    output banks_t o_banks
);

    logic   r_we_d;
    logic   r_set_d;
    idx_t   r_idx;
    banks_t r_banks;

    // Align strobe and bank select with the lagging coefficient word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we_d  <= 1'b0;
            r_set_d <= 1'b0;
        end else begin
            r_we_d  <= i_coef_we;
            r_set_d <= i_coef_set_in;
        end
    end

    // Tap index: parked at 0 between bursts so every burst starts at tap 0,
    // wraps after the last tap so an over-long burst rewrites from tap 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
        end else if (!r_we_d) begin
            r_idx <= '0;
        end else if (r_idx == LAST_IDX) begin
            r_idx <= '0;
        end else begin
            r_idx <= r_idx + idx_t'(1);
        end
    end

    // Coefficient storage: defaults on reset, single-tap write per reload cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    r_banks[s][k] <= default_coef(s[0], idx_t'(k));
                end
            end
        end else if (r_we_d) begin
            r_banks[r_set_d][r_idx] <= i_coef_in;
        end
    end

    assign o_banks = r_banks;

endmodule

// File: rtl/fir91_coef_reload.sv
// Direct-form FIR with two run-time reloadable coefficient banks. Stage 1 is
// the sample delay line plus the captured bank select and error tag; stage 2
// is the full-precision MAC, saturation and the output register. Both stages
// advance together whenever the output register is free or being drained.
module fir91_coef_reload
    import fir91_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    fir91_coef_reload_if.slave   bus
);

    logic   w_adv;
    logic   w_accept;
    banks_t w_banks;
    acc_t   w_acc;
    dout_t  w_sat;

    din_t   r_x [NUM_TAPS];
    logic   r_s1_valid;
    logic   r_s1_set;
    err_t   r_s1_err;
    dout_t  r_src_data;
    logic   r_src_valid;
    err_t   r_src_err;

    fir91_coef_bank u_bank (
        .clk           (clk),
        .reset         (reset),
        .i_coef_we     (bus.coef_we),
        .i_coef_set_in (bus.coef_set_in),
        .i_coef_in     (bus.coef_in),
        .o_banks       (w_banks)
    );

    // Pipeline moves when the output slot is empty or being taken this cycle
    assign w_adv    = !r_src_valid || bus.ast_source_ready;
    assign w_accept = bus.ast_sink_valid && w_adv;

    assign bus.ast_sink_ready   = w_adv;
    assign bus.ast_source_data  = r_src_data;
    assign bus.ast_source_valid = r_src_valid;
    assign bus.ast_source_error = r_src_err;

    // Delay line: shifts only when a sample is accepted, so idle cycles add no zeros
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else if (w_accept) begin
            r_x[0] <= bus.ast_sink_data;
            for (int k = 1; k < NUM_TAPS; k++) begin
                r_x[k] <= r_x[k-1];
            end
        end
    end

    // Stage-1 sideband: valid follows accept on every advance; bank and error ride with the sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_set   <= 1'b0;
            r_s1_err   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_set <= bus.coef_set;
                r_s1_err <= bus.ast_sink_error;
            end
        end
    end

    // MAC over the whole delay line with the bank captured alongside the newest sample;
    // coefficients are read live, so a tap written on the same edge is seen with its old value
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_acc = w_acc + mac_term(r_x[k], coef_t'(w_banks[r_s1_set][k]));
        end
    end

    assign w_sat = saturate(w_acc);

    // Output register: loads on advance, holds everything while the sink stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_data  <= '0;
            r_src_valid <= 1'b0;
            r_src_err   <= '0;
        end else if (w_adv) begin
            r_src_data  <= w_sat;
            r_src_valid <= r_s1_valid;
            r_src_err   <= r_s1_err;
        end
    end

endmodule

// File: tb/tb_fir91_coef_reload.sv
// Directed + randomized bench for fir91_coef_reload. A behavioural model keeps
// the accepted-sample history and both coefficient banks as plain arrays and
// computes each expected result as a saturated dot product.
module tb_fir91_coef_reload;
  import fir91_pkg::*;

  localparam int W = DOUT_WIDTH + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir91_coef_reload_if bus ();

  fir91_coef_reload dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_asserts = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  int hist[$];
  int mbank[2][NUM_TAPS];
  logic [DOUT_WIDTH-1:0] last_out;
  int bp_mode = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    exp_q.delete();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < NUM_TAPS; k++)
        mbank[s][k] = (k == 0) ? s + 1 : 0;
  endfunction

  function automatic logic [W-1:0] model_out(int set, logic [1:0] err);
    longint acc = 0;
    longint lim = longint'(1) << (DOUT_WIDTH - 1);
    foreach (hist[k]) acc += longint'(hist[k]) * longint'(mbank[set][k]);
    if (acc > lim - 1) acc = lim - 1;
    else if (acc < -lim) acc = -lim;
    return {err, acc[DOUT_WIDTH-1:0]};
  endfunction

  // ---------------- monitor (samples on falling edge) ----------------
  logic [W:0] held;
  bit stalled = 0;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 0;
    end else begin
      if (stalled)
        check("stall_hold", 64'({bus.ast_source_valid, bus.ast_source_error, bus.ast_source_data}), 64'(held));
      check("sink_ready_adv", 64'(bus.ast_sink_ready), 64'(!bus.ast_source_valid || bus.ast_source_ready));
      if (bus.ast_source_valid && bus.ast_source_ready) begin
        n_asserts++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_output observed=%0h expected=none", bus.ast_source_data);
        end
        if (exp_q.size() > 0)
          check("sb_result", 64'({bus.ast_source_error, bus.ast_source_data}), 64'(exp_q.pop_front()));
        last_out = bus.ast_source_data;
      end
      if (bus.ast_sink_valid && bus.ast_sink_ready) begin
        hist.push_front(int'(bus.ast_sink_data));
        if (hist.size() > NUM_TAPS) void'(hist.pop_back());
        exp_q.push_back(model_out(int'(bus.coef_set), bus.ast_sink_error));
      end
      stalled = bus.ast_source_valid && !bus.ast_source_ready;
      held = {bus.ast_source_valid, bus.ast_source_error, bus.ast_source_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.ast_sink_data = '0;
    bus.ast_sink_valid = 1'b0;
    bus.ast_sink_error = '0;
    bus.coef_set = 1'b0;
    bus.ast_source_ready = 1'b1;
    bus.coef_we = 1'b0;
    bus.coef_set_in = 1'b0;
    bus.coef_in = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (bp_mode)
      1: bus.ast_source_ready = ~bus.ast_source_ready;
      2: bus.ast_source_ready = 1'($urandom_range(0, 1));
      default: bus.ast_source_ready = 1'b1;
    endcase
  endtask

  task automatic send(int d, bit set, logic [1:0] err);
    bit got;
    got = 0;
    bus.ast_sink_valid = 1'b1;
    bus.ast_sink_data = din_t'(d);
    bus.coef_set = set;
    bus.ast_sink_error = err;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = bus.ast_sink_ready;
      tick();
    end
    n_asserts++;
    assert (got) else begin
      n_fail++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic reload(bit set, input int vals[$], bit stream1);
    int n;
    n = vals.size();
    for (int i = 0; i <= n; i++) begin
      bus.coef_we = (i < n);
      bus.coef_set_in = set;
      bus.coef_in = (i == 0) ? coef_t'(0) : coef_t'(vals[i-1]);
      if (stream1) begin
        bus.ast_sink_valid = 1'b1;
        bus.ast_sink_data = din_t'(int'($urandom_range(0, 65535)) - 32768);
        bus.coef_set = 1'b1;
        bus.ast_sink_error = 2'($urandom_range(0, 3));
      end
      tick();
    end
    bus.coef_we = 1'b0;
    bus.coef_in = '0;
    bus.ast_sink_valid = 1'b0;
    for (int i = 0; i < n; i++) mbank[set][i % NUM_TAPS] = vals[i];
  endtask

  task automatic drain(string tag);
    bus.ast_sink_valid = 1'b0;
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) tick();
    check({"drain_", tag}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  int v[$];
  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (3) tick();
    check("rst_src_valid", 64'(bus.ast_source_valid), 64'd0);
    check("rst_src_data", 64'(bus.ast_source_data), 64'd0);
    check("rst_src_err", 64'(bus.ast_source_error), 64'd0);
    check("rst_sink_ready", 64'(bus.ast_sink_ready), 64'd1);
    reset = 1'b0;
    tick();

    // Impulse through default bank0 with explicit latency checks
    bus.ast_sink_valid = 1'b1;
    bus.ast_sink_data = din_t'(1000);
    bus.coef_set = 1'b0;
    bus.ast_sink_error = 2'd1;
    tick();
    check("lat1_valid", 64'(bus.ast_source_valid), 64'd0);
    bus.ast_sink_data = '0;
    bus.ast_sink_error = '0;
    tick();
    check("lat2_valid", 64'(bus.ast_source_valid), 64'd1);
    check("lat2_data", 64'(bus.ast_source_data), 64'd1000);
    check("lat2_err", 64'(bus.ast_source_error), 64'd1);
    repeat (5) tick();
    drain("impulse_b0");

    // Default bank1 and per-sample bank switching
    send(1000, 1, 2'd2);
    for (int i = 0; i < 5; i++) send(0, 1, 2'd0);
    send(100, 0, 2'd3);
    send(100, 1, 2'd0);
    send(100, 0, 2'd1);
    send(-7, 1, 2'd2);
    drain("bank1_toggle");

    // Reload bank0 with 1..80 while streaming on bank1, then read it back by impulse
    v.delete();
    for (int i = 0; i < NUM_TAPS; i++) v.push_back(i + 1);
    reload(0, v, 1);
    drain("reload_stream");
    send(1, 0, 2'd0);
    for (int i = 0; i < NUM_TAPS; i++) send(0, 0, 2'd0);
    drain("ramp_taps");

    // Full bank1 reload, then a short burst to check the coef_in lag and partial update
    v.delete();
    for (int i = 0; i < NUM_TAPS; i++) v.push_back(100 + i);
    reload(1, v, 0);
    v.delete();
    v.push_back(7); v.push_back(8); v.push_back(9);
    reload(1, v, 0);
    send(1, 1, 2'd0);
    for (int i = 0; i < 5; i++) send(0, 1, 2'd0);
    drain("short_burst");
    check("tap3_kept", 64'(last_out), 64'(38'd105));

    // Backpressure: source_ready toggling during a ramp
    bp_mode = 1;
    for (int i = 1; i <= 40; i++) send(i, 0, 2'(i));
    drain("backpressure");
    bp_mode = 0;

    // Random samples, banks, tags, gaps and source_ready
    bp_mode = 2;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.ast_sink_valid = 1'b0;
        tick();
      end else begin
        send(int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
    end
    drain("random");
    bp_mode = 0;

    // Saturation: full-scale negative input through max coefficients
    v.delete();
    for (int i = 0; i < NUM_TAPS; i++) v.push_back(262143);
    reload(0, v, 0);
    for (int i = 0; i < NUM_TAPS + 5; i++) send(-32768, 0, 2'd0);
    drain("saturation");
    check("sat_clamp", 64'(last_out), 64'({1'b1, {(DOUT_WIDTH-1){1'b0}}}));

    // Reset in the middle of a stream
    bus.ast_sink_valid = 1'b1;
    bus.ast_sink_data = din_t'(500);
    bus.coef_set = 1'b1;
    bus.ast_sink_error = 2'd3;
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.ast_source_valid), 64'd0);
    check("midrst_data", 64'(bus.ast_source_data), 64'd0);
    check("midrst_sink_ready", 64'(bus.ast_sink_ready), 64'd1);
    bus.ast_sink_valid = 1'b0;
    model_reset();
    tick();
    reset = 1'b0;
    tick();
    send(1, 0, 2'd0);
    for (int i = 0; i < 3; i++) send(0, 0, 2'd0);
    send(3, 1, 2'd1);
    send(0, 1, 2'd0);
    drain("post_reset");

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
